// File: rtl/audio_pkg.sv
// Shared audio capture types.
// Recorder states and PCM word width.
package audio_pkg;

    localparam int PCM_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RECORD,
        FINISH
    } rec_state_t;

endpackage

// File: rtl/pdm_record_ctrl.sv
// PDM capture sequencer: enables the deserializer, discards settle words,
// then streams each completed word into sample RAM until stop or full.
module pdm_record_ctrl
    import audio_pkg::*;
#(
    parameter int ADDR_W       = 14,
    parameter int MAX_WORDS    = 16384,
    parameter int SETTLE_WORDS = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              deser_done,
    input  logic [PCM_W-1:0]  deser_data,
    output logic              deser_enable,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PCM_W-1:0]  mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              full,
    output logic              rec_done
);

    // Settle counter runs 0..SETTLE_WORDS-1; keep at least one bit.
    localparam int SW = (SETTLE_WORDS > 1) ? $clog2(SETTLE_WORDS) : 1;
    localparam int SETTLE_LAST_I = (SETTLE_WORDS > 0) ? SETTLE_WORDS - 1 : 0;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_LAST_I);
    localparam logic [ADDR_W:0] MAX_LAST = (ADDR_W + 1)'(MAX_WORDS - 1);

    rec_state_t      state;
    rec_state_t      state_next;
    logic [SW-1:0]   settle_cnt;
    logic            cap_clr;
    logic            settle_inc;
    logic            wr;
    logic            set_full;

    // Next-state and per-cycle datapath controls.
    always_comb begin
        state_next = state;
        cap_clr    = 1'b0;
        settle_inc = 1'b0;
        wr         = 1'b0;
        set_full   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    cap_clr    = 1'b1;
                    state_next = (SETTLE_WORDS == 0) ? RECORD : SETTLE;
                end
            end
            SETTLE: begin
                if (stop) begin
                    state_next = FINISH;
                end else if (deser_done) begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state_next = RECORD;
                    end else begin
                        settle_inc = 1'b1;
                    end
                end
            end
            RECORD: begin
                if (deser_done) begin
                    wr = 1'b1;
                    if (word_count == MAX_LAST) begin
                        set_full   = 1'b1;
                        state_next = FINISH;
                    end
                end
                if (stop) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered outputs, counters and the RAM write port.
    always_ff @(posedge clock) begin
        if (reset) begin
            deser_enable <= 1'b0;
            busy         <= 1'b0;
            rec_done     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            word_count   <= '0;
            full         <= 1'b0;
            settle_cnt   <= '0;
        end else begin
            deser_enable <= (state_next == SETTLE) || (state_next == RECORD);
            busy         <= (state_next == SETTLE) || (state_next == RECORD);
            rec_done     <= (state_next == FINISH);
            mem_we       <= wr;
            if (cap_clr) begin
                word_count <= '0;
                full       <= 1'b0;
                settle_cnt <= '0;
            end
            if (settle_inc) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
            if (wr) begin
                mem_addr   <= word_count[ADDR_W-1:0];
                mem_wdata  <= deser_data;
                word_count <= word_count + 1'b1;
            end
            if (set_full) begin
                full <= 1'b1;
            end
        end
    end

endmodule

// File: doc/pdm_record_ctrl.md
# pdm_record_ctrl

Sequences PDM microphone capture into sample memory. Enables the PDM deserializer, discards its first words while the microphone settles, then writes each completed 16-bit word to a single-port block RAM at consecutive addresses. Capture stops on user request or when memory fills. Sits between the button/UI logic and the deserializer/RAM pair.

## Interface
Parameters:
- ADDR_W, 14, sample memory address width
- MAX_WORDS, 16384, words captured before auto-stop; must be 1..2**ADDR_W
- SETTLE_WORDS, 4, deserializer words discarded after each enable; 0 allowed

Ports:
- clock  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high
- start  in  1  single-cycle request; begins a capture from IDLE
- stop  in  1  single-cycle request; ends an active capture
- deser_done  in  1  one-cycle pulse from deserializer; deser_data valid that cycle
- deser_data  in  16  deserialized PDM word
- deser_enable  out  1  deserializer enable
- mem_we  out  1  RAM write strobe
- mem_addr  out  ADDR_W  RAM write address
- mem_wdata  out  16  RAM write data
- word_count  out  ADDR_W+1  words written in current/last capture
- busy  out  1  high in SETTLE or RECORD
- full  out  1  sticky; last capture ended at MAX_WORDS
- rec_done  out  1  one-cycle pulse at end of every capture

## Operation
- States: IDLE, SETTLE, RECORD, FINISH.
- IDLE: deser_enable=0. start -> clear word_count, full, settle counter -> SETTLE (or RECORD if SETTLE_WORDS=0). stop ignored.
- SETTLE: deser_enable=1. Count deser_done pulses; after SETTLE_WORDS pulses -> RECORD. No RAM writes. stop -> FINISH with word_count=0.
- RECORD: deser_enable=1. Each deser_done registers deser_data into mem_wdata and mem_addr=word_count[ADDR_W-1:0], pulses mem_we; word_count increments in the same registered update.
- Write that makes word_count reach MAX_WORDS -> set full, go to FINISH.
- stop in RECORD -> FINISH. If deser_done occurs the same cycle, that word is still written.
- FINISH: one cycle; deser_enable=0, rec_done=1 -> IDLE.
- start while busy or in FINISH: ignored. start and stop together in IDLE: start wins.
- Dropping deser_enable resets the deserializer's bit counter; every capture therefore starts word-aligned.

## Timing
- All outputs registered. Reset values: deser_enable=0, mem_we=0, mem_addr=0, mem_wdata=0, word_count=0, busy=0, full=0, rec_done=0, state IDLE.
- start at cycle N -> deser_enable and busy high from N+1.
- deser_done at cycle N in RECORD -> mem_we high for exactly cycle N+1 with the corresponding address/data; word_count updated at N+1.
- Deserializer pulses arrive >=16 cycles apart; one write slot per pulse, no buffering.
- Terminating event at N (stop, or final write) -> FINISH at N+1 (deser_enable=0, rec_done=1, busy=0) -> IDLE at N+2. Final write's mem_we coincides with the FINISH cycle.
- mem_addr holds its last value when mem_we=0; mem_wdata likewise.
- word_count saturates at MAX_WORDS; never wraps.
- Reset in any state: return to IDLE next cycle with reset values. Any in-flight write is dropped, with no rec_done.

## Structure
- Shared package audio_pkg: state enum rec_state_t {IDLE, SETTLE, RECORD, FINISH}, PCM_W=16 constant.
- Single module; settle counter, word counter and write register inline. No sub-module needed. Deserializer and RAM are instantiated by the parent as peers.

## Test plan
- SETTLE_WORDS=4, MAX_WORDS=8: start, drive deser_done every 16 cycles with data 0xA000+k -> first 4 words are not written; the next 8 are written to addrs 0..7 with data 0xA004..0xA00B; full=1, one rec_done, word_count=8.
- stop pulse after 3 written words -> FINISH next cycle, word_count=3, full=0, deser_enable low.
- stop in the same cycle as deser_done in RECORD -> that word is written (mem_we in FINISH cycle), word_count increments.
- start during RECORD, and stop in IDLE -> no state change, no extra rec_done.
- reset asserted while mem_we would fire next cycle -> no write, all outputs 0, IDLE; a following start clears full and restarts at addr 0.
- SETTLE_WORDS=0 -> first deser_done after start writes addr 0.
